// File: rtl/iqmap_rd_arb.sv
// Two-source FWFT word arbiter feeding the BPSK IQ mapper reader port; grant 1 cycle, word 1 cycle after map_reader_en.
// Sources are popped combinationally only on map_reader_en; enable low ends the stream at the next request.
module iqmap_rd_arb #(
  parameter int W     = 128,
  parameter int BURST = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         enable,
  input  logic         prio,
  input  logic         ch0_valid,
  input  logic         ch1_valid,
  input  logic [W-1:0] ch0_data,
  input  logic [W-1:0] ch1_data,
  output logic         ch0_ready,
  output logic         ch1_ready,
  output logic         map_ce,
  output logic         map_valid,
  input  logic         map_reader_en,
  output logic [W-1:0] map_reader_data,
  output logic         map_src,
  output logic         busy,
  output logic [15:0]  cnt0,
  output logic [15:0]  cnt1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam int            GW       = $clog2(BURST + 1);
  localparam logic [GW-1:0] BURST_G  = GW'(BURST);
  localparam logic [GW-1:0] GCNT_ONE = GW'(1);

  state_t        state_q, state_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          last_q, last_d;
  logic          map_valid_q, map_valid_d;
  logic          map_ce_q, map_ce_d;
  logic [W-1:0]  rd_dat_q, rd_dat_d;
  logic          src_q, src_d;
  logic [15:0]   cnt0_q, cnt0_d;
  logic [15:0]   cnt1_q, cnt1_d;

  logic arb_vld;
  logic arb_ch;
  logic held_ch;
  logic held_vld;
  logic serve_vld;
  logic serve_ch;

  // Round-robin favours the channel not granted last; fixed priority always favours ch0.
  always_comb begin
    arb_vld = 1'b0;
    arb_ch  = 1'b0;
    if (prio) begin
      if (ch0_valid) begin
        arb_vld = 1'b1;
        arb_ch  = 1'b0;
      end else if (ch1_valid) begin
        arb_vld = 1'b1;
        arb_ch  = 1'b1;
      end
    end else if (last_q ? ch0_valid : ch1_valid) begin
      arb_vld = 1'b1;
      arb_ch  = ~last_q;
    end else if (last_q ? ch1_valid : ch0_valid) begin
      arb_vld = 1'b1;
      arb_ch  = last_q;
    end
  end

  assign held_ch  = (state_q == GRANT1);
  assign held_vld = held_ch ? ch1_valid : ch0_valid;

  always_comb begin
    state_d     = state_q;
    gcnt_d      = gcnt_q;
    last_d      = last_q;
    map_valid_d = map_valid_q;
    serve_vld   = 1'b0;
    serve_ch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && arb_vld) begin
          state_d     = arb_ch ? GRANT1 : GRANT0;
          gcnt_d      = '0;
          last_d      = arb_ch;
          map_valid_d = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (map_reader_en) begin
          if (enable && held_vld && (gcnt_q < BURST_G)) begin
            serve_vld = 1'b1;
            serve_ch  = held_ch;
            gcnt_d    = gcnt_q + GCNT_ONE;
          end else if (enable && arb_vld) begin
            // Re-arbitration serves the winner in this same request, so no bubble.
            serve_vld = 1'b1;
            serve_ch  = arb_ch;
            state_d   = arb_ch ? GRANT1 : GRANT0;
            gcnt_d    = GCNT_ONE;
            last_d    = arb_ch;
          end else begin
            state_d     = IDLE;
            map_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        map_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_dat_d = rd_dat_q;
    src_d    = src_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    map_ce_d = enable;
    if (serve_vld) begin
      src_d = serve_ch;
      if (serve_ch) begin
        rd_dat_d = ch1_data;
        cnt1_d   = cnt1_q + 16'd1;
      end else begin
        rd_dat_d = ch0_data;
        cnt0_d   = cnt0_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      gcnt_q      <= '0;
      last_q      <= 1'b1;
      map_valid_q <= 1'b0;
      map_ce_q    <= 1'b0;
      rd_dat_q    <= '0;
      src_q       <= 1'b0;
      cnt0_q      <= 16'd0;
      cnt1_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      last_q      <= last_d;
      map_valid_q <= map_valid_d;
      map_ce_q    <= map_ce_d;
      rd_dat_q    <= rd_dat_d;
      src_q       <= src_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign ch0_ready       = serve_vld && !serve_ch;
  assign ch1_ready       = serve_vld && serve_ch;
  assign map_ce          = map_ce_q;
  assign map_valid       = map_valid_q;
  assign map_reader_data = rd_dat_q;
  assign map_src         = src_q;
  assign busy            = (state_q == GRANT0) || (state_q == GRANT1);
  assign cnt0            = cnt0_q;
  assign cnt1            = cnt1_q;

endmodule

// File: tb/tb_iqmap_rd_arb.sv
// Directed bench for iqmap_rd_arb (BURST=2): reset, single stream, fixed priority, round-robin, stop, counter wrap.
module tb_iqmap_rd_arb;

  localparam int W   = 128;
  localparam int BIG = 1000000;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         enable = 1'b0;
  logic         prio = 1'b0;
  logic         ch0_valid, ch1_valid;
  logic [W-1:0] ch0_data, ch1_data;
  logic         ch0_ready, ch1_ready;
  logic         map_ce, map_valid;
  logic         map_reader_en = 1'b0;
  logic [W-1:0] map_reader_data;
  logic         map_src, busy;
  logic [15:0]  cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  // FWFT source model: word k (1-based) of each channel has a channel tag in the top bits.
  int   i0 = 0, i1 = 0;
  int   n0 = 0, n1 = 0;
  logic src_clr = 1'b1;

  function automatic logic [W-1:0] mkw(input logic c, input int k);
    return {(c ? 32'hC1C1_0000 : 32'hC0C0_0000), 64'h0, 32'(k)};
  endfunction

  always @(posedge CLK) begin
    if (src_clr) begin
      i0 <= 0;
      i1 <= 0;
    end else begin
      if (ch0_ready) i0 <= i0 + 1;
      if (ch1_ready) i1 <= i1 + 1;
    end
  end

  assign ch0_valid = (i0 < n0);
  assign ch1_valid = (i1 < n1);
  assign ch0_data  = mkw(1'b0, i0 + 1);
  assign ch1_data  = mkw(1'b1, i1 + 1);

  always #5 CLK = ~CLK;

  iqmap_rd_arb #(.W(W), .BURST(2)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .enable          (enable),
    .prio            (prio),
    .ch0_valid       (ch0_valid),
    .ch1_valid       (ch1_valid),
    .ch0_data        (ch0_data),
    .ch1_data        (ch1_data),
    .ch0_ready       (ch0_ready),
    .ch1_ready       (ch1_ready),
    .map_ce          (map_ce),
    .map_valid       (map_valid),
    .map_reader_en   (map_reader_en),
    .map_reader_data (map_reader_data),
    .map_src         (map_src),
    .busy            (busy),
    .cnt0            (cnt0),
    .cnt1            (cnt1)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One reader request: pop strobes are checked in the request cycle, the word one cycle later.
  task automatic rd(input string tag, input logic r0, input logic r1,
                    input logic [W-1:0] dat, input logic src);
    map_reader_en = 1'b1;
    #1;
    chk({tag, ":rdy0"}, W'(ch0_ready), W'(r0));
    chk({tag, ":rdy1"}, W'(ch1_ready), W'(r1));
    tick();
    map_reader_en = 1'b0;
    chk({tag, ":dat"}, map_reader_data, dat);
    chk({tag, ":src"}, W'(map_src), W'(src));
  endtask

  initial begin
    // Reset state
    #1 RST = 1'b0;
    #1;
    chk("rst_valid", W'(map_valid), 0);
    chk("rst_ce", W'(map_ce), 0);
    chk("rst_dat", map_reader_data, 0);
    chk("rst_src", W'(map_src), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_cnt0", W'(cnt0), 0);
    chk("rst_cnt1", W'(cnt1), 0);
    chk("rst_rdy0", W'(ch0_ready), 0);
    chk("rst_rdy1", W'(ch1_ready), 0);
    tick();
    RST = 1'b1;
    src_clr = 1'b0;

    // Single stream: three ch0 words, fourth request ends the stream
    n0 = 3;
    enable = 1'b1;
    chk("ss_valid_pre", W'(map_valid), 0);
    tick();
    chk("ss_valid_grant", W'(map_valid), 1);
    chk("ss_busy_grant", W'(busy), 1);
    chk("ss_ce", W'(map_ce), 1);
    rd("ss_w1", 1'b1, 1'b0, mkw(1'b0, 1), 1'b0);
    rd("ss_w2", 1'b1, 1'b0, mkw(1'b0, 2), 1'b0);
    rd("ss_w3", 1'b1, 1'b0, mkw(1'b0, 3), 1'b0);
    chk("ss_valid_w3", W'(map_valid), 1);
    rd("ss_end", 1'b0, 1'b0, mkw(1'b0, 3), 1'b0);
    chk("ss_valid_end", W'(map_valid), 0);
    chk("ss_busy_end", W'(busy), 0);
    chk("ss_cnt0", W'(cnt0), 3);
    chk("ss_cnt1", W'(cnt1), 0);

    // Fixed priority: ch0 holds words 4..6, ch1 only after ch0 empties
    prio = 1'b1;
    n0 = 6;
    n1 = BIG;
    tick();
    chk("fp_busy", W'(busy), 1);
    rd("fp_a", 1'b1, 1'b0, mkw(1'b0, 4), 1'b0);
    rd("fp_b", 1'b1, 1'b0, mkw(1'b0, 5), 1'b0);
    rd("fp_c", 1'b1, 1'b0, mkw(1'b0, 6), 1'b0);
    rd("fp_d", 1'b0, 1'b1, mkw(1'b1, 1), 1'b1);
    chk("fp_valid_sw", W'(map_valid), 1);
    rd("fp_e", 1'b0, 1'b1, mkw(1'b1, 2), 1'b1);
    chk("fp_cnt0", W'(cnt0), 6);
    chk("fp_cnt1", W'(cnt1), 2);

    // Reset mid-grant in GRANT1 with cnt1 = 5
    rd("mg_a", 1'b0, 1'b1, mkw(1'b1, 3), 1'b1);
    rd("mg_b", 1'b0, 1'b1, mkw(1'b1, 4), 1'b1);
    rd("mg_c", 1'b0, 1'b1, mkw(1'b1, 5), 1'b1);
    chk("mg_cnt1", W'(cnt1), 5);
    chk("mg_busy", W'(busy), 1);
    #2 RST = 1'b0;
    #1;
    chk("ar_valid", W'(map_valid), 0);
    chk("ar_ce", W'(map_ce), 0);
    chk("ar_dat", map_reader_data, 0);
    chk("ar_src", W'(map_src), 0);
    chk("ar_busy", W'(busy), 0);
    chk("ar_cnt0", W'(cnt0), 0);
    chk("ar_cnt1", W'(cnt1), 0);
    map_reader_en = 1'b1;
    #1;
    chk("ar_rdy0", W'(ch0_ready), 0);
    chk("ar_rdy1", W'(ch1_ready), 0);
    map_reader_en = 1'b0;
    src_clr = 1'b1;
    n0 = BIG;
    n1 = BIG;
    prio = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    src_clr = 1'b0;
    chk("rel_valid", W'(map_valid), 0);
    tick();
    chk("rel_grant", W'(map_valid), 1);

    // Round-robin with BURST=2, one request every 8 cycles
    for (int j = 0; j < 8; j++) begin
      logic rc;
      int   rk;
      rc = 1'(j / 2 % 2);
      rk = (j / 4) * 2 + (j % 2) + 1;
      rd($sformatf("rr_%0d", j), ~rc, rc, mkw(rc, rk), rc);
      for (int g = 0; g < 7; g++) begin
        tick();
        chk($sformatf("rr_gap_%0d", j), W'(map_valid), 1);
      end
    end
    chk("rr_cnt0", W'(cnt0), 4);
    chk("rr_cnt1", W'(cnt1), 4);

    // Graceful stop: ch1 runs dry, two ch0 words, then enable drops
    n1 = 4;
    rd("gs_a", 1'b1, 1'b0, mkw(1'b0, 5), 1'b0);
    rd("gs_b", 1'b1, 1'b0, mkw(1'b0, 6), 1'b0);
    enable = 1'b0;
    tick();
    chk("gs_ce", W'(map_ce), 0);
    chk("gs_valid_hold", W'(map_valid), 1);
    rd("gs_stop", 1'b0, 1'b0, mkw(1'b0, 6), 1'b0);
    chk("gs_valid", W'(map_valid), 0);
    chk("gs_busy", W'(busy), 0);
    chk("gs_cnt0", W'(cnt0), 6);

    // Counter wrap: 65537 ch1 words from a fresh reset
    RST = 1'b0;
    src_clr = 1'b1;
    n0 = 0;
    n1 = BIG;
    enable = 1'b1;
    tick();
    RST = 1'b1;
    src_clr = 1'b0;
    tick();
    chk("cw_busy", W'(busy), 1);
    map_reader_en = 1'b1;
    repeat (65537) @(posedge CLK);
    #1;
    map_reader_en = 1'b0;
    chk("cw_cnt1", W'(cnt1), 1);
    chk("cw_cnt0", W'(cnt0), 0);
    chk("cw_src", W'(map_src), 1);
    chk("cw_dat", map_reader_data, mkw(1'b1, 65537));
    chk("cw_valid", W'(map_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
